button_event_classifier: RTL and testbench
==========================================

// Module: button_event_classifier
// PURPOSE
//  Consumes the debounced level and edge pulses of one push-button. Classifies each
//  gesture as short press, double click or long press, and emits auto-repeat pulses
//  while a long press is held. Sits directly downstream of the button debouncer and
//  drives the lab control FSMs with single-cycle, registered event pulses.
// PARAMETERS
//  CLK_HZ            10_000_000  system clock frequency in Hz
//  Simulacion        0           1 selects the *_SIM tick counts instead of ms-derived ones
//  LONG_MS           800         hold time before long_pulse (hardware)
//  DOUBLE_MS         300         max release-to-second-press gap for a double click (hardware)
//  REPEAT_MS         200         auto-repeat period while long-held (hardware)
//  LONG_TICKS_SIM    8           LONG_TICKS when Simulacion=1
//  DOUBLE_TICKS_SIM  4           DOUBLE_TICKS when Simulacion=1
//  REPEAT_TICKS_SIM  3           REPEAT_TICKS when Simulacion=1
//  Derived: X_TICKS = Simulacion ? X_TICKS_SIM : (CLK_HZ/1000)*X_MS; all X_TICKS >= 2.
//  Counter width = $clog2(max of the three TICKS)+1.
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  reset          in   1  synchronous, active-high
//  pressed        in   1  debounced button level (1 = held)
//  press_pulse    in   1  1-cycle pulse on debounced press
//  release_pulse  in   1  1-cycle pulse on debounced release
//  short_pulse    out  1  1-cycle: single short press completed
//  double_pulse   out  1  1-cycle: double click completed
//  long_pulse     out  1  1-cycle: hold reached LONG_TICKS
//  repeat_pulse   out  1  1-cycle: auto-repeat tick during long hold
//  hold           out  1  level: high while in LONG state
// BEHAVIOUR
//  - Reset (sync): state=IDLE, cnt=0, all outputs 0. Any gesture in progress is dropped.
//    No event is emitted for it after reset.
//  - All outputs are registered. A pulse goes high in the cycle after the cycle in which
//    its condition is true. Each pulse lasts exactly 1 cycle.
//  - One counter, cnt. It is cleared on every state change and increments each cycle.
//  - Timing notation: the press_pulse cycle is cycle 0. State after the edge ending
//    cycle k is the state in cycle k+1.
//  - States and transitions:
//    IDLE:   press_pulse -> PRESS1.
//    PRESS1: release_pulse -> WAIT2.
//            Else cnt==LONG_TICKS-1 -> LONG and long_pulse.
//    WAIT2:  press_pulse -> PRESS2.
//            Else cnt==DOUBLE_TICKS-1 -> IDLE and short_pulse.
//    PRESS2: release_pulse -> IDLE and double_pulse. No timeout; no long detection here.
//    LONG:   release_pulse -> IDLE, with no pulse emitted.
//            Else cnt==REPEAT_TICKS-1 and pressed -> repeat_pulse, cnt<=0.
//            hold=1 during every LONG cycle and 0 in all other states.
//  - Resulting latencies:
//    long_pulse in cycle LONG_TICKS+1.
//    First repeat_pulse at LONG_TICKS+REPEAT_TICKS+1, then every REPEAT_TICKS cycles.
//    short_pulse at release cycle + DOUBLE_TICKS + 1.
//  - Priorities:
//    Release beats the long or repeat timeout in the same cycle.
//    Press beats the WAIT2 timeout in the same cycle.
//    If press_pulse and release_pulse are both high, release_pulse is honoured and
//    press_pulse is ignored.
//  - Pulses not expected in the current state are ignored: press_pulse outside IDLE and
//    WAIT2, and release_pulse in IDLE and WAIT2.
//  - At most one output pulse in any cycle. cnt never wraps: every state exits or reloads
//    cnt at its terminal value.
// TESTING (Simulacion=1: LONG=8, DOUBLE=4, REPEAT=3)
//  1 short: press c0, release c3 -> short_pulse only in c8; no other pulses; hold=0 throughout.
//  2 double: press c0, release c3, press c5, release c7 -> double_pulse in c8; no short_pulse.
//  3 long+repeat: press c0, release c20 -> long_pulse c9; repeat_pulse c12,c15,c18; none at c21.
//    hold=1 during c9..c20, 0 from c21.
//  4 boundary: press c0, release c8 (cnt=7) -> no long_pulse; short_pulse in c13.
//  5 press at timeout: press c0, release c3, press c7 -> no short_pulse; then release c9 ->
//    double_pulse in c10.
//  6 reset mid-gesture: press c0, release c3, reset high in c5 -> all outputs 0 from c6.
//    No short_pulse ever; a fresh press in c8 is classified normally.

Source files
------------

// File: rtl/button_event_classifier.sv
// -----------------------------------------------------------------------------
// button_event_classifier
//
// Turns the debounced level and edge pulses of one push-button into gesture
// events: single short press, double click, and long press. While a long press
// is held it also emits periodic auto-repeat pulses. It sits directly after the
// debouncer and drives the lab control FSMs with single-cycle, registered
// event pulses.
//
// Parameters
//   CLK_HZ            system clock frequency in Hz
//   Simulacion        1 selects the *_SIM tick counts instead of ms-derived ones
//   LONG_MS           hold time before long_pulse
//   DOUBLE_MS         max release-to-second-press gap for a double click
//   REPEAT_MS         auto-repeat period while long-held
//   LONG_TICKS_SIM    long hold in ticks when Simulacion=1
//   DOUBLE_TICKS_SIM  double-click gap in ticks when Simulacion=1
//   REPEAT_TICKS_SIM  repeat period in ticks when Simulacion=1
//
// Ports
//   clk            in   system clock, all logic on posedge
//   reset          in   synchronous, active-high
//   pressed        in   debounced button level (1 = held)
//   press_pulse    in   1-cycle pulse on debounced press
//   release_pulse  in   1-cycle pulse on debounced release
//   short_pulse    out  1-cycle: single short press completed
//   double_pulse   out  1-cycle: double click completed
//   long_pulse     out  1-cycle: hold reached the long threshold
//   repeat_pulse   out  1-cycle: auto-repeat tick during long hold
//   hold           out  level: high while a long press is held
// -----------------------------------------------------------------------------
module button_event_classifier #(
  parameter int CLK_HZ           = 10_000_000,
  parameter int Simulacion       = 0,
  parameter int LONG_MS          = 800,
  parameter int DOUBLE_MS        = 300,
  parameter int REPEAT_MS        = 200,
  parameter int LONG_TICKS_SIM   = 8,
  parameter int DOUBLE_TICKS_SIM = 4,
  parameter int REPEAT_TICKS_SIM = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed,
  input  logic press_pulse,
  input  logic release_pulse,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic hold
);

  localparam int TICKS_PER_MS = CLK_HZ / 1000;

  localparam int LONG_TICKS   = (Simulacion != 0) ? LONG_TICKS_SIM   : TICKS_PER_MS * LONG_MS;
  localparam int DOUBLE_TICKS = (Simulacion != 0) ? DOUBLE_TICKS_SIM : TICKS_PER_MS * DOUBLE_MS;
  localparam int REPEAT_TICKS = (Simulacion != 0) ? REPEAT_TICKS_SIM : TICKS_PER_MS * REPEAT_MS;

  localparam int MAX_LD    = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
  localparam int MAX_TICKS = (MAX_LD > REPEAT_TICKS) ? MAX_LD : REPEAT_TICKS;

  // One spare bit above the largest terminal value, so the saturating
  // increment in the untimed states never collides with a terminal count.
  localparam int CNT_W = $clog2(MAX_TICKS) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LONG_LAST   = cnt_t'(LONG_TICKS - 1);
  localparam cnt_t DOUBLE_LAST = cnt_t'(DOUBLE_TICKS - 1);
  localparam cnt_t REPEAT_LAST = cnt_t'(REPEAT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping; only the
  // untimed state PRESS2 can run long enough to need it.
  function automatic cnt_t cnt_sat_inc(input cnt_t c);
    cnt_t r;
    if (c == '1) begin
      r = c;
    end else begin
      r = c + cnt_t'(1);
    end
    return r;
  endfunction

  state_t state_q, state_d;
  cnt_t   cnt_q,   cnt_d;

  logic short_q,  short_d;
  logic double_q, double_d;
  logic long_q,   long_d;
  logic repeat_q, repeat_d;
  logic hold_q,   hold_d;

  // A simultaneous release wins over a press, so the press is masked here
  // once rather than in every state that listens for it.
  logic press_eff;
  assign press_eff = press_pulse & ~release_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_sat_inc(cnt_q);
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (press_eff) begin
          state_d = S_PRESS1;
        end
      end

      // Release is checked first so it wins over the long timeout.
      S_PRESS1: begin
        if (release_pulse) begin
          state_d = S_WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end
      end

      // A second press arriving on the timeout cycle still makes a double.
      S_WAIT2: begin
        if (press_eff) begin
          state_d = S_PRESS2;
        end else if (cnt_q == DOUBLE_LAST) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end

      S_PRESS2: begin
        if (release_pulse) begin
          state_d  = S_IDLE;
          double_d = 1'b1;
        end
      end

      // The period counter reloads at its terminal value even if the level
      // has dropped, so it cannot wrap; only a held button fires a repeat.
      S_LONG: begin
        if (release_pulse) begin
          state_d = S_IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = pressed;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    hold_d = (state_d == S_LONG);
  end

  assign short_pulse  = short_q;
  assign double_pulse = double_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign hold         = hold_q;

endmodule

// File: tb/tb_button_event_classifier.sv
module tb_button_event_classifier;

  localparam int LT = 8;
  localparam int DT = 4;
  localparam int RT = 3;

  // Gesture phases of the reference model
  localparam int M_IDLE   = 0;
  localparam int M_FIRST  = 1;
  localparam int M_GAP    = 2;
  localparam int M_SECOND = 3;
  localparam int M_HELD   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pressed = 1'b0;
  logic press_pulse = 1'b0;
  logic release_pulse = 1'b0;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, hold;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: phase plus an absolute-cycle deadline
  int   ph = M_IDLE;
  int   deadline = 0;
  int   cyc = 0;
  logic lvl = 1'b0;
  logic [4:0] exp_v = '0;
  logic [4:0] obs;

  button_event_classifier #(
    .CLK_HZ(10_000_000),
    .Simulacion(1),
    .LONG_MS(800),
    .DOUBLE_MS(300),
    .REPEAT_MS(200),
    .LONG_TICKS_SIM(LT),
    .DOUBLE_TICKS_SIM(DT),
    .REPEAT_TICKS_SIM(RT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .short_pulse(short_pulse),
    .double_pulse(double_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse),
    .hold(hold)
  );

  always #5 clk = ~clk;

  assign obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, hold};

  // Drives one cycle of inputs, advances the reference model for that cycle
  // (exp_v becomes the outputs expected in the following cycle), and returns
  // 1 time unit after the clock edge.
  task automatic cyc_step(input logic pp, input logic rp, input logic rst);
    logic e_s, e_d, e_l, e_r;
    if (rp) lvl = 1'b0;
    else if (pp) lvl = 1'b1;
    press_pulse   = pp;
    release_pulse = rp;
    pressed       = lvl;
    reset         = rst;
    e_s = 1'b0; e_d = 1'b0; e_l = 1'b0; e_r = 1'b0;
    if (rst) begin
      ph = M_IDLE;
    end else begin
      case (ph)
        M_IDLE: if (pp && !rp) begin ph = M_FIRST; deadline = cyc + LT; end
        M_FIRST: begin
          if (rp) begin ph = M_GAP; deadline = cyc + DT; end
          else if (cyc == deadline) begin ph = M_HELD; e_l = 1'b1; deadline = cyc + RT; end
        end
        M_GAP: begin
          if (pp && !rp) ph = M_SECOND;
          else if (cyc == deadline) begin ph = M_IDLE; e_s = 1'b1; end
        end
        M_SECOND: if (rp) begin ph = M_IDLE; e_d = 1'b1; end
        M_HELD: begin
          if (rp) ph = M_IDLE;
          else if (cyc == deadline) begin deadline = cyc + RT; e_r = lvl; end
        end
        default: ph = M_IDLE;
      endcase
    end
    exp_v = {e_s, e_d, e_l, e_r, (ph == M_HELD)};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) cyc_step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cyc_step(1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs !== 5'b0) begin
        n_fail++;
        $display("FAIL reset k%0d: got %b expected %b", k, obs, 5'b0);
      end
    end
    // Press during reset must not start a gesture
    cyc_step(1'b1, 1'b0, 1'b1);
    lvl = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc_step(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (obs !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_quiet k%0d: got %b expected %b", k, obs, 5'b0);
      end
    end
  endtask

  task automatic test_short();
    for (int k = 0; k < 14; k++) begin
      cyc_step(k == 0, k == 3, 1'b0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL short_model c%0d: got %b expected %b", k + 1, obs, exp_v);
      end
      n_chk++;
      if (obs !== {(k + 1 == 8), 4'b0}) begin
        n_fail++;
        $display("FAIL short c%0d: got %b expected %b", k + 1, obs, {(k + 1 == 8), 4'b0});
      end
    end
  endtask

  task automatic test_double();
    for (int k = 0; k < 14; k++) begin
      cyc_step(k == 0 || k == 5, k == 3 || k == 7, 1'b0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL double_model c%0d: got %b expected %b", k + 1, obs, exp_v);
      end
      n_chk++;
      if (obs !== {1'b0, (k + 1 == 8), 3'b0}) begin
        n_fail++;
        $display("FAIL double c%0d: got %b expected %b", k + 1, obs, {1'b0, (k + 1 == 8), 3'b0});
      end
    end
  endtask

  task automatic test_long_repeat();
    int c;
    logic [4:0] want;
    for (int k = 0; k < 24; k++) begin
      cyc_step(k == 0, k == 20, 1'b0);
      c = k + 1;
      want = {1'b0, 1'b0, (c == 9), (c == 12 || c == 15 || c == 18), (c >= 9 && c <= 20)};
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL long_model c%0d: got %b expected %b", c, obs, exp_v);
      end
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL long_repeat c%0d: got %b expected %b", c, obs, want);
      end
    end
  endtask

  task automatic test_boundary();
    for (int k = 0; k < 16; k++) begin
      cyc_step(k == 0, k == 8, 1'b0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL boundary_model c%0d: got %b expected %b", k + 1, obs, exp_v);
      end
      n_chk++;
      if (obs !== {(k + 1 == 13), 4'b0}) begin
        n_fail++;
        $display("FAIL boundary c%0d: got %b expected %b", k + 1, obs, {(k + 1 == 13), 4'b0});
      end
    end
  endtask

  task automatic test_press_at_timeout();
    for (int k = 0; k < 14; k++) begin
      cyc_step(k == 0 || k == 7, k == 3 || k == 9, 1'b0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL press_timeout_model c%0d: got %b expected %b", k + 1, obs, exp_v);
      end
      n_chk++;
      if (obs !== {1'b0, (k + 1 == 10), 3'b0}) begin
        n_fail++;
        $display("FAIL press_timeout c%0d: got %b expected %b", k + 1, obs, {1'b0, (k + 1 == 10), 3'b0});
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 18; k++) begin
      cyc_step(k == 0 || k == 8, k == 3 || k == 10, k == 5);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_model c%0d: got %b expected %b", k + 1, obs, exp_v);
      end
      n_chk++;
      if (obs !== {(k + 1 == 15), 4'b0}) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got %b expected %b", k + 1, obs, {(k + 1 == 15), 4'b0});
      end
    end
  endtask

  task automatic test_simultaneous();
    // Both pulses in IDLE: release wins, press ignored, nothing starts
    for (int k = 0; k < 12; k++) begin
      cyc_step(k == 0, k == 0, 1'b0);
      n_chk++;
      if (obs !== 5'b0) begin
        n_fail++;
        $display("FAIL simultaneous c%0d: got %b expected %b", k + 1, obs, 5'b0);
      end
    end
  endtask

  task automatic test_random();
    logic pp, rp, rst;
    int busy;
    int pulses;
    pulses = 0;
    for (int k = 0; k < 3000; k++) begin
      pp = 1'b0; rp = 1'b0; rst = 1'b0;
      if (!lvl && $urandom_range(0, 3) == 0) pp = 1'b1;
      else if (lvl && $urandom_range(0, 6) == 0) rp = 1'b1;
      if ($urandom_range(0, 59) == 0) begin pp = 1'b1; rp = 1'b1; end
      if ($urandom_range(0, 79) == 0) pp = 1'b1;
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      cyc_step(pp, rp, rst);
      busy = (obs[4:1] != 4'b0) ? 1 : 0;
      pulses += busy;
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random c%0d: got %b expected %b", cyc, obs, exp_v);
      end
      n_chk++;
      if ((obs[4] + obs[3] + obs[2] + obs[1]) > 1) begin
        n_fail++;
        $display("FAIL one_pulse c%0d: got %b expected at most one pulse", cyc, obs);
      end
    end
    n_chk++;
    if (pulses == 0) begin
      n_fail++;
      $display("FAIL random_activity: got %0d pulses expected nonzero", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    idle_gap(4);
    test_double();
    idle_gap(4);
    test_long_repeat();
    idle_gap(4);
    test_boundary();
    idle_gap(4);
    test_press_at_timeout();
    idle_gap(4);
    test_reset_mid();
    idle_gap(4);
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
